// File: rtl/correl_peak_detect.sv
// Peak search over the matched-filter correlator output: |x|^2 per beat, maximum per frame,
// one {index, magnitude} result per frame with threshold-detect and framing-error flags.
module correl_peak_detect #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10,
  parameter int MAG_W     = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_W-1:0]      S_AXIS_RE_tdata,
  input  logic                   S_AXIS_RE_tvalid,
  input  logic                   S_AXIS_RE_tlast,
  output logic                   S_AXIS_RE_tready,
  input  logic [DATA_W-1:0]      S_AXIS_IM_tdata,
  input  logic                   S_AXIS_IM_tvalid,
  output logic                   S_AXIS_IM_tready,
  input  logic [MAG_W-1:0]       thresh,
  output logic [IDX_W+MAG_W-1:0] M_AXIS_PEAK_tdata,
  output logic                   M_AXIS_PEAK_tvalid,
  input  logic                   M_AXIS_PEAK_tready,
  output logic                   peak_detect,
  output logic                   frame_err
);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // Squares of 16-bit signed values fit in 31 unsigned bits; arithmetic mod 2^31 is exact here.
  localparam int               SQ_W     = 2 * DATA_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     drain_cnt_r;
  logic                     tready_r;
  logic [IDX_W-1:0]         cnt_r;
  logic                     beat_s;
  logic                     first_s;
  logic                     end_s;
  logic                     err_s;
  logic                     handshake_s;
  logic                     out_load_s;
  logic [MAG_W-1:0]         thresh_r;
  logic                     ferr_r;
  logic [SQ_W-1:0]          re_ext_s;
  logic [SQ_W-1:0]          im_ext_s;
  logic [SQ_W-1:0]          re_sq_s;
  logic [SQ_W-1:0]          im_sq_s;
  logic                     p1_valid_r;
  logic                     p1_first_r;
  logic [IDX_W-1:0]         p1_idx_r;
  logic [SQ_W-1:0]          p1_re2_r;
  logic [SQ_W-1:0]          p1_im2_r;
  logic [MAG_W-1:0]         mag_s;
  logic [MAG_W-1:0]         max_r;
  logic [IDX_W-1:0]         max_idx_r;
  logic                     tvalid_r;
  logic [IDX_W+MAG_W-1:0]   tdata_r;
  logic                     pd_r;
  logic                     fe_r;

  assign beat_s      = S_AXIS_RE_tvalid & S_AXIS_IM_tvalid & tready_r;
  assign first_s     = (cnt_r == {IDX_W{1'b0}});
  assign end_s       = S_AXIS_RE_tlast | (cnt_r == LAST_IDX);
  // Short frame (early tlast) or forced close (full count without tlast).
  assign err_s       = S_AXIS_RE_tlast ? (cnt_r != LAST_IDX) : (cnt_r == LAST_IDX);
  assign handshake_s = tvalid_r & M_AXIS_PEAK_tready;
  assign out_load_s  = (state_r == ST_OUTPUT) & ~tvalid_r;

  assign re_ext_s = {{(SQ_W-DATA_W){S_AXIS_RE_tdata[DATA_W-1]}}, S_AXIS_RE_tdata};
  assign im_ext_s = {{(SQ_W-DATA_W){S_AXIS_IM_tdata[DATA_W-1]}}, S_AXIS_IM_tdata};
  assign re_sq_s  = re_ext_s * re_ext_s;
  assign im_sq_s  = im_ext_s * im_ext_s;
  assign mag_s    = MAG_W'(p1_re2_r) + MAG_W'(p1_im2_r);

  assign S_AXIS_RE_tready   = tready_r;
  assign S_AXIS_IM_tready   = tready_r;
  assign M_AXIS_PEAK_tdata  = tdata_r;
  assign M_AXIS_PEAK_tvalid = tvalid_r;
  assign peak_detect        = pd_r;
  assign frame_err          = fe_r;

  // Next-state decode for the accumulate / drain / output sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (beat_s && end_s) state_nxt_s = ST_DRAIN;
        else                 state_nxt_s = ST_ACCUM;
      end
      ST_DRAIN: begin
        if (drain_cnt_r) state_nxt_s = ST_OUTPUT;
        else             state_nxt_s = ST_DRAIN;
      end
      ST_OUTPUT: begin
        if (handshake_s) state_nxt_s = ST_ACCUM;
        else             state_nxt_s = ST_OUTPUT;
      end
      default: state_nxt_s = ST_ACCUM;
    endcase
  end

  // Control state, input ready, beat counter and per-frame latched threshold / error.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r     <= ST_ACCUM;
      drain_cnt_r <= 1'b0;
      tready_r    <= 1'b0;
      cnt_r       <= {IDX_W{1'b0}};
      thresh_r    <= {MAG_W{1'b0}};
      ferr_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tready_r    <= (state_nxt_s == ST_ACCUM);
      drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + 1'b1) : 1'b0;
      if (beat_s) begin
        cnt_r <= end_s ? {IDX_W{1'b0}} : (cnt_r + {{(IDX_W-1){1'b0}}, 1'b1});
        if (first_s) thresh_r <= thresh;
        if (end_s)   ferr_r   <= err_s;
      end
    end
  end

  // Two-stage squaring / magnitude pipeline with running maximum (ties keep the earlier index).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      p1_valid_r <= 1'b0;
      p1_first_r <= 1'b0;
      p1_idx_r   <= {IDX_W{1'b0}};
      p1_re2_r   <= {SQ_W{1'b0}};
      p1_im2_r   <= {SQ_W{1'b0}};
      max_r      <= {MAG_W{1'b0}};
      max_idx_r  <= {IDX_W{1'b0}};
    end else begin
      p1_valid_r <= beat_s;
      if (beat_s) begin
        p1_first_r <= first_s;
        p1_idx_r   <= cnt_r;
        p1_re2_r   <= re_sq_s;
        p1_im2_r   <= im_sq_s;
      end
      if (p1_valid_r && (p1_first_r || (mag_s > max_r))) begin
        max_r     <= mag_s;
        max_idx_r <= p1_idx_r;
      end
    end
  end

  // Result beat: captured once on entry to OUTPUT, held stable until the handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tvalid_r <= 1'b0;
      tdata_r  <= {(IDX_W+MAG_W){1'b0}};
      pd_r     <= 1'b0;
      fe_r     <= 1'b0;
    end else begin
      tvalid_r <= (state_r == ST_OUTPUT) & ~handshake_s;
      if (out_load_s) begin
        tdata_r <= {max_idx_r, max_r};
        pd_r    <= (max_r >= thresh_r);
        fe_r    <= ferr_r;
      end else if (handshake_s) begin
        pd_r <= 1'b0;
        fe_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_correl_peak_detect.sv
// Directed bench for correl_peak_detect: peak search, ties, short/forced frames,
// output back-pressure, mid-frame reset and back-to-back frames.
module tb_correl_peak_detect;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 1024;
  localparam int IDX_W     = 10;
  localparam int MAG_W     = 32;

  logic                   aclk;
  logic                   aresetn;
  logic [DATA_W-1:0]      re_tdata;
  logic                   re_tvalid;
  logic                   re_tlast;
  logic                   re_tready;
  logic [DATA_W-1:0]      im_tdata;
  logic                   im_tvalid;
  logic                   im_tready;
  logic [MAG_W-1:0]       thresh;
  logic [IDX_W+MAG_W-1:0] peak_tdata;
  logic                   peak_tvalid;
  logic                   peak_tready;
  logic                   peak_detect;
  logic                   frame_err;

  int tests = 0;
  int fails = 0;

  correl_peak_detect #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W), .MAG_W(MAG_W)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .S_AXIS_RE_tdata    (re_tdata),
    .S_AXIS_RE_tvalid   (re_tvalid),
    .S_AXIS_RE_tlast    (re_tlast),
    .S_AXIS_RE_tready   (re_tready),
    .S_AXIS_IM_tdata    (im_tdata),
    .S_AXIS_IM_tvalid   (im_tvalid),
    .S_AXIS_IM_tready   (im_tready),
    .thresh             (thresh),
    .M_AXIS_PEAK_tdata  (peak_tdata),
    .M_AXIS_PEAK_tvalid (peak_tvalid),
    .M_AXIS_PEAK_tready (peak_tready),
    .peak_detect        (peak_detect),
    .frame_err          (frame_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one RE/IM beat and wait (bounded) until it is accepted.
  task automatic send_beat(input int re, input int im, input bit last);
    logic acc;
    logic rdy;
    acc       = 1'b0;
    re_tdata  = 16'(re);
    im_tdata  = 16'(im);
    re_tlast  = last;
    re_tvalid = 1'b1;
    im_tvalid = 1'b1;
    for (int w = 0; w < 64 && !acc; w++) begin
      rdy = re_tready;
      @(posedge aclk);
      #1;
      acc = rdy;
    end
    chk("beat_accept", {63'd0, acc}, 64'd1);
  endtask

  // Frame of n beats, all zero except indices ia / ib; thresh switched after beat 0.
  task automatic send_frame(input int n, input bit with_last,
                            input int ia, input int ra, input int ma,
                            input int ib, input int rb, input int mb,
                            input logic [31:0] th_first, input logic [31:0] th_after,
                            input bit hold);
    int re;
    int im;
    thresh = th_first;
    for (int i = 0; i < n; i++) begin
      re = (i == ia) ? ra : ((i == ib) ? rb : 0);
      im = (i == ia) ? ma : ((i == ib) ? mb : 0);
      send_beat(re, im, with_last && (i == n - 1));
      if (i == 0) thresh = th_after;
    end
    re_tdata = 16'd0;
    im_tdata = 16'd0;
    re_tlast = 1'b0;
    re_tvalid = hold;
    im_tvalid = hold;
  endtask

  // Called right after the last-beat edge: latency, content, back-pressure hold, handshake.
  task automatic check_result(input int exp_idx, input logic [31:0] exp_mag,
                              input bit exp_pd, input bit exp_fe, input int hold);
    logic [41:0] exp_data;
    exp_data = {10'(exp_idx), exp_mag};
    for (int k = 1; k <= 3; k++) begin
      @(posedge aclk);
      #1;
      chk("tvalid_latency", {63'd0, peak_tvalid}, (k == 3) ? 64'd1 : 64'd0);
      chk("in_tready_low", {63'd0, re_tready}, 64'd0);
    end
    chk("tdata", {22'd0, peak_tdata}, {22'd0, exp_data});
    chk("peak_detect", {63'd0, peak_detect}, {63'd0, exp_pd});
    chk("frame_err", {63'd0, frame_err}, {63'd0, exp_fe});
    for (int h = 0; h < hold; h++) begin
      @(posedge aclk);
      #1;
      chk("hold_tdata", {22'd0, peak_tdata}, {22'd0, exp_data});
      chk("hold_tvalid", {63'd0, peak_tvalid}, 64'd1);
      chk("hold_in_tready", {63'd0, re_tready}, 64'd0);
    end
    peak_tready = 1'b1;
    @(posedge aclk);
    #1;
    peak_tready = 1'b0;
    chk("tvalid_after_accept", {63'd0, peak_tvalid}, 64'd0);
    chk("tready_after_accept", {63'd0, re_tready}, 64'd1);
    chk("im_tready_after_accept", {63'd0, im_tready}, 64'd1);
  endtask

  initial begin
    aresetn     = 1'b0;
    re_tdata    = 16'd0;
    im_tdata    = 16'd0;
    re_tvalid   = 1'b0;
    im_tvalid   = 1'b0;
    re_tlast    = 1'b0;
    thresh      = 32'd0;
    peak_tready = 1'b0;

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", {63'd0, re_tready}, 64'd0);
    chk("rst_tvalid", {63'd0, peak_tvalid}, 64'd0);
    chk("rst_tdata", {22'd0, peak_tdata}, 64'd0);
    chk("rst_pd", {63'd0, peak_detect}, 64'd0);
    chk("rst_fe", {63'd0, frame_err}, 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("tready_after_rst", {63'd0, re_tready}, 64'd1);

    // 1: full frame, single peak at 300
    send_frame(1024, 1'b1, 300, 1000, -1000, -1, 0, 0, 32'd1000000, 32'd1000000, 1'b0);
    check_result(300, 32'd2000000, 1'b1, 1'b0, 0);

    // 2: tie between idx 5 and 900 at full-scale negative, lowest index wins
    send_frame(1024, 1'b1, 5, -32768, -32768, 900, -32768, -32768,
               32'd1000000, 32'd1000000, 1'b0);
    check_result(5, 32'h8000_0000, 1'b1, 1'b0, 0);

    // 3: short frame (tlast on beat 511), then a clean frame; thresh change mid-frame ignored
    send_frame(512, 1'b1, 100, 3, 4, -1, 0, 0, 32'd1000000, 32'd1000000, 1'b0);
    check_result(100, 32'd25, 1'b0, 1'b1, 0);
    send_frame(1024, 1'b1, 1023, 2, -3, -1, 0, 0, 32'd13, 32'd14, 1'b0);
    check_result(1023, 32'd13, 1'b1, 1'b0, 0);

    // 4: forced close without tlast, back-pressure for 20 cycles, then a 1-beat tlast frame
    send_frame(1024, 1'b0, 1023, 100, 0, -1, 0, 0, 32'd10000, 32'd10000, 1'b0);
    check_result(1023, 32'd10000, 1'b1, 1'b1, 20);
    send_frame(1, 1'b1, 0, 5, 5, -1, 0, 0, 32'd51, 32'd51, 1'b0);
    check_result(0, 32'd50, 1'b0, 1'b1, 0);

    // 5: reset after 400 beats, aborted frame yields nothing
    send_frame(400, 1'b0, 200, 1000, 1000, -1, 0, 0, 32'd0, 32'd0, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    chk("midrst_tready", {63'd0, re_tready}, 64'd0);
    chk("midrst_tvalid", {63'd0, peak_tvalid}, 64'd0);
    @(posedge aclk);
    #1;
    chk("midrst_tready_back", {63'd0, re_tready}, 64'd1);
    chk("midrst_no_result", {63'd0, peak_tvalid}, 64'd0);
    send_frame(1024, 1'b1, 7, -7, 24, -1, 0, 0, 32'd1000, 32'd1000, 1'b0);
    check_result(7, 32'd625, 1'b0, 1'b0, 0);

    // 6: back-to-back short frames with valid held high between them
    send_frame(16, 1'b1, 3, 10, 0, -1, 0, 0, 32'd0, 32'd0, 1'b1);
    check_result(3, 32'd100, 1'b1, 1'b1, 0);
    send_frame(16, 1'b1, 15, 0, -20, -1, 0, 0, 32'd400, 32'd400, 1'b0);
    check_result(15, 32'd400, 1'b1, 1'b1, 0);
    repeat (4) @(posedge aclk);
    #1;
    chk("no_extra_result", {63'd0, peak_tvalid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
